// File: rtl/shared_divmod_sched.sv
`default_nettype none
// ============================================================================
// Module   : shared_divmod_sched
// Purpose  : Round-robin scheduler sharing one restoring divide/modulo unit
//            between NREQ requesters; returns quotient and remainder together.
// Revision : 1.0 - initial release
// ============================================================================
module shared_divmod_sched #(
  parameter int DATAWIDTH = 64,
  parameter int NREQ      = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*DATAWIDTH-1:0] ReqDividend,
  input  logic [NREQ*DATAWIDTH-1:0] ReqDivisor,
  output logic [NREQ-1:0]           Grant,
  output logic [NREQ-1:0]           Done,
  output logic [DATAWIDTH-1:0]      Quot,
  output logic [DATAWIDTH-1:0]      Rem,
  output logic                      DivZero,
  output logic                      Busy
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_PW-1:0]      r_last, w_last_nxt;
  logic [c_PW-1:0]      r_owner, w_owner_nxt;
  logic [DATAWIDTH-1:0] r_dvd, w_dvd_nxt;
  logic [DATAWIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [DATAWIDTH-1:0] r_acc, w_acc_nxt;
  logic [c_CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]      w_grant_nxt, w_done_nxt;
  logic [DATAWIDTH-1:0] w_quot_nxt, w_rem_nxt;
  logic                 w_dz_nxt, w_busy_nxt;

  // Round-robin search starting just after the last granted requester
  logic                 w_found;
  logic [c_PW-1:0]      w_sel, w_cand;
  logic [NREQ-1:0]      w_sel_oh;
  logic [DATAWIDTH-1:0] w_sel_dvd, w_sel_dvs;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = c_PW'((int'(r_last) + k) % NREQ);
      if (!w_found && Req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_sel_oh  = NREQ'(1) << w_sel;
  assign w_sel_dvd = ReqDividend[w_sel*DATAWIDTH +: DATAWIDTH];
  assign w_sel_dvs = ReqDivisor[w_sel*DATAWIDTH +: DATAWIDTH];

  // One restoring step; the subtractor's borrow bit decides the quotient bit
  logic [DATAWIDTH:0]   w_acc_sh, w_diff;
  logic                 w_ge;
  logic [DATAWIDTH-1:0] w_acc_new, w_dvd_new;

  assign w_acc_sh  = {r_acc, r_dvd[DATAWIDTH-1]};
  assign w_diff    = w_acc_sh - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[DATAWIDTH];
  assign w_acc_new = w_ge ? w_diff[DATAWIDTH-1:0] : w_acc_sh[DATAWIDTH-1:0];
  assign w_dvd_new = {r_dvd[DATAWIDTH-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_quot_nxt  = Quot;
    w_rem_nxt   = Rem;
    w_dz_nxt    = DivZero;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel_oh;
          w_owner_nxt = w_sel;
          w_last_nxt  = w_sel;
          w_dvd_nxt   = w_sel_dvd;
          w_dvs_nxt   = w_sel_dvs;
          w_acc_nxt   = '0;
          w_cnt_nxt   = c_CW'(DATAWIDTH);
          if (w_sel_dvs != '0) begin
            w_state_nxt = CALC;
          end else begin
            w_state_nxt = FIN;
            w_done_nxt  = w_sel_oh;
            w_quot_nxt  = '1;
            w_rem_nxt   = w_sel_dvd;
            w_dz_nxt    = 1'b1;
          end
        end
      end
      CALC: begin
        // Quotient bits shift into the dividend register as it empties
        w_dvd_nxt = w_dvd_new;
        w_acc_nxt = w_acc_new;
        w_cnt_nxt = r_cnt - c_CW'(1);
        if (r_cnt == c_CW'(1)) begin
          w_state_nxt = FIN;
          w_done_nxt  = NREQ'(1) << r_owner;
          w_quot_nxt  = w_dvd_new;
          w_rem_nxt   = w_acc_new;
          w_dz_nxt    = 1'b0;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_last  <= c_PW'(NREQ - 1);
      r_owner <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      Grant   <= '0;
      Done    <= '0;
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      Grant   <= w_grant_nxt;
      Done    <= w_done_nxt;
      Quot    <= w_quot_nxt;
      Rem     <= w_rem_nxt;
      DivZero <= w_dz_nxt;
      Busy    <= w_busy_nxt;
    end
  end

endmodule
`default_nettype wire
